// File: rtl/l2_req_arbiter.sv
// Merges dcache, icache and prefetch requests onto the single L1-to-L2 request
// channel: dc/ic round-robin, prefetch lowest with anti-starvation, 2-entry output FIFO.
module l2_req_arbiter #(
    parameter int unsigned         DCID_W    = 5,
    parameter int unsigned         CMD_W     = 3,
    parameter int unsigned         PCSIGN_W  = 13,
    parameter int unsigned         LADDR_W   = 39,
    parameter int unsigned         SPTBR_W   = 38,
    parameter logic [CMD_W-1:0]    PF_CMD    = 3'd7,
    parameter logic [DCID_W-1:0]   PF_DCID   = 5'd31,
    parameter int unsigned         PF_STARVE = 15
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                dc_req_valid,
    output logic                dc_req_retry,
    input  logic [DCID_W-1:0]   dc_req_dcid,
    input  logic [CMD_W-1:0]    dc_req_cmd,
    input  logic [PCSIGN_W-1:0] dc_req_pcsign,
    input  logic [LADDR_W-1:0]  dc_req_laddr,
    input  logic [SPTBR_W-1:0]  dc_req_sptbr,

    input  logic                ic_req_valid,
    output logic                ic_req_retry,
    input  logic [DCID_W-1:0]   ic_req_dcid,
    input  logic [CMD_W-1:0]    ic_req_cmd,
    input  logic [PCSIGN_W-1:0] ic_req_pcsign,
    input  logic [LADDR_W-1:0]  ic_req_laddr,
    input  logic [SPTBR_W-1:0]  ic_req_sptbr,

    input  logic                pf_req_valid,
    output logic                pf_req_retry,
    input  logic [LADDR_W-1:0]  pf_req_laddr,
    input  logic [SPTBR_W-1:0]  pf_req_sptbr,

    output logic                l1tol2_req_valid,
    input  logic                l1tol2_req_retry,
    output logic [DCID_W-1:0]   l1tol2_req_dcid,
    output logic [CMD_W-1:0]    l1tol2_req_cmd,
    output logic [PCSIGN_W-1:0] l1tol2_req_pcsign,
    output logic [LADDR_W-1:0]  l1tol2_req_laddr,
    output logic [SPTBR_W-1:0]  l1tol2_req_sptbr
);

    localparam int unsigned ENT_W = DCID_W + CMD_W + PCSIGN_W + LADDR_W + SPTBR_W;
    localparam int unsigned PFW_W = $clog2(PF_STARVE + 1);
    localparam logic [PFW_W-1:0] PF_MAX = PFW_W'(PF_STARVE);

    typedef enum logic [1:0] {GNT_NONE, GNT_DC, GNT_IC, GNT_PF} grant_e;
    typedef enum logic {RR_DC, RR_IC} rr_e;

    logic [ENT_W-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    rr_e              r_rr_last;
    logic [PFW_W-1:0] r_pf_wait;

    grant_e           w_grant;
    logic             w_space;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_entry;

    // Space comes from the registered count only; a same-cycle pop does not free a slot.
    assign w_space = (r_count != 2'd2);
    assign w_push  = (w_grant != GNT_NONE);
    assign w_pop   = l1tol2_req_valid && !l1tol2_req_retry;

    always_comb begin
        w_grant = GNT_NONE;
        if (reset && w_space) begin
            if (pf_req_valid && (r_pf_wait == PF_MAX))
                w_grant = GNT_PF;
            else if (dc_req_valid && ic_req_valid)
                w_grant = (r_rr_last == RR_DC) ? GNT_IC : GNT_DC;
            else if (dc_req_valid)
                w_grant = GNT_DC;
            else if (ic_req_valid)
                w_grant = GNT_IC;
            else if (pf_req_valid)
                w_grant = GNT_PF;
        end
    end

    always_comb begin
        w_entry = '0;
        case (w_grant)
            GNT_DC:  w_entry = {dc_req_dcid, dc_req_cmd, dc_req_pcsign, dc_req_laddr, dc_req_sptbr};
            GNT_IC:  w_entry = {ic_req_dcid, ic_req_cmd, ic_req_pcsign, ic_req_laddr, ic_req_sptbr};
            GNT_PF:  w_entry = {PF_DCID, PF_CMD, {PCSIGN_W{1'b0}}, pf_req_laddr, pf_req_sptbr};
            default: w_entry = '0;
        endcase
    end

    assign dc_req_retry = (w_grant != GNT_DC);
    assign ic_req_retry = (w_grant != GNT_IC);
    assign pf_req_retry = (w_grant != GNT_PF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= '0;
            r_rr_last <= RR_IC;
            r_pf_wait <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_entry;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop)
                r_rptr <= ~r_rptr;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);

            if (w_grant == GNT_DC)
                r_rr_last <= RR_DC;
            else if (w_grant == GNT_IC)
                r_rr_last <= RR_IC;

            if (!pf_req_valid || (w_grant == GNT_PF))
                r_pf_wait <= '0;
            else if (r_pf_wait != PF_MAX)
                r_pf_wait <= r_pf_wait + PFW_W'(1);
        end
    end

    assign l1tol2_req_valid = (r_count != 2'd0);
    assign {l1tol2_req_dcid, l1tol2_req_cmd, l1tol2_req_pcsign,
            l1tol2_req_laddr, l1tol2_req_sptbr} = r_mem[r_rptr];

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Directed-vector bench for l2_req_arbiter with hand-computed expectations.
module tb_l2_req_arbiter;

    localparam int unsigned DCID_W   = 5;
    localparam int unsigned CMD_W    = 3;
    localparam int unsigned PCSIGN_W = 13;
    localparam int unsigned LADDR_W  = 39;
    localparam int unsigned SPTBR_W  = 38;

    logic                clk = 1'b0;
    logic                reset;
    logic                dc_req_valid, dc_req_retry;
    logic [DCID_W-1:0]   dc_req_dcid;
    logic [CMD_W-1:0]    dc_req_cmd;
    logic [PCSIGN_W-1:0] dc_req_pcsign;
    logic [LADDR_W-1:0]  dc_req_laddr;
    logic [SPTBR_W-1:0]  dc_req_sptbr;
    logic                ic_req_valid, ic_req_retry;
    logic [DCID_W-1:0]   ic_req_dcid;
    logic [CMD_W-1:0]    ic_req_cmd;
    logic [PCSIGN_W-1:0] ic_req_pcsign;
    logic [LADDR_W-1:0]  ic_req_laddr;
    logic [SPTBR_W-1:0]  ic_req_sptbr;
    logic                pf_req_valid, pf_req_retry;
    logic [LADDR_W-1:0]  pf_req_laddr;
    logic [SPTBR_W-1:0]  pf_req_sptbr;
    logic                l1tol2_req_valid, l1tol2_req_retry;
    logic [DCID_W-1:0]   l1tol2_req_dcid;
    logic [CMD_W-1:0]    l1tol2_req_cmd;
    logic [PCSIGN_W-1:0] l1tol2_req_pcsign;
    logic [LADDR_W-1:0]  l1tol2_req_laddr;
    logic [SPTBR_W-1:0]  l1tol2_req_sptbr;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic        exp_dc;

    always #5 clk = ~clk;

    l2_req_arbiter #(
        .DCID_W(5), .CMD_W(3), .PCSIGN_W(13), .LADDR_W(39), .SPTBR_W(38),
        .PF_CMD(3'd7), .PF_DCID(5'd31), .PF_STARVE(15)
    ) dut (
        .clk(clk), .reset(reset),
        .dc_req_valid(dc_req_valid), .dc_req_retry(dc_req_retry),
        .dc_req_dcid(dc_req_dcid), .dc_req_cmd(dc_req_cmd), .dc_req_pcsign(dc_req_pcsign),
        .dc_req_laddr(dc_req_laddr), .dc_req_sptbr(dc_req_sptbr),
        .ic_req_valid(ic_req_valid), .ic_req_retry(ic_req_retry),
        .ic_req_dcid(ic_req_dcid), .ic_req_cmd(ic_req_cmd), .ic_req_pcsign(ic_req_pcsign),
        .ic_req_laddr(ic_req_laddr), .ic_req_sptbr(ic_req_sptbr),
        .pf_req_valid(pf_req_valid), .pf_req_retry(pf_req_retry),
        .pf_req_laddr(pf_req_laddr), .pf_req_sptbr(pf_req_sptbr),
        .l1tol2_req_valid(l1tol2_req_valid), .l1tol2_req_retry(l1tol2_req_retry),
        .l1tol2_req_dcid(l1tol2_req_dcid), .l1tol2_req_cmd(l1tol2_req_cmd),
        .l1tol2_req_pcsign(l1tol2_req_pcsign), .l1tol2_req_laddr(l1tol2_req_laddr),
        .l1tol2_req_sptbr(l1tol2_req_sptbr)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b0;
        l1tol2_req_retry = 1'b0;
        dc_req_valid = 1'b1; dc_req_dcid = 5'd3; dc_req_cmd = 3'd1;
        dc_req_pcsign = 13'h1ab; dc_req_laddr = 39'h100; dc_req_sptbr = 38'h11;
        ic_req_valid = 1'b0; ic_req_dcid = 5'd2; ic_req_cmd = 3'd2;
        ic_req_pcsign = 13'h0cd; ic_req_laddr = 39'h200; ic_req_sptbr = 38'h22;
        pf_req_valid = 1'b0; pf_req_laddr = 39'h2000; pf_req_sptbr = 38'h55;

        // Reset state
        cyc(); cyc();
        chk("rst_valid", l1tol2_req_valid, 0);
        chk("rst_dc_retry", dc_req_retry, 1);
        chk("rst_dcid", l1tol2_req_dcid, 0);

        // Single dc transfer, one-cycle latency
        reset = 1'b1;
        #1 chk("t1_dc_retry", dc_req_retry, 0);
        chk("t1_valid_c0", l1tol2_req_valid, 0);
        cyc();
        chk("t1_valid_c1", l1tol2_req_valid, 1);
        chk("t1_dcid", l1tol2_req_dcid, 3);
        chk("t1_laddr", l1tol2_req_laddr, 39'h100);
        dc_req_valid = 1'b0;
        #1 chk("t1_dc_retry_idle", dc_req_retry, 1);
        cyc();
        chk("t1_drained", l1tol2_req_valid, 0);

        // dc/ic round-robin; rr_last is dc after the previous transfer, so ic goes first
        dc_req_valid = 1'b1; dc_req_dcid = 5'd1;
        ic_req_valid = 1'b1; ic_req_dcid = 5'd2;
        for (int i = 0; i < 6; i++) begin
            exp_dc = (i % 2) == 1;
            #1 chk("t2_dc_retry", dc_req_retry, !exp_dc);
            chk("t2_ic_retry", ic_req_retry, exp_dc);
            cyc();
            chk("t2_valid", l1tol2_req_valid, 1);
            chk("t2_dcid", l1tol2_req_dcid, exp_dc ? 5'd1 : 5'd2);
        end
        dc_req_valid = 1'b0; ic_req_valid = 1'b0;
        cyc();
        chk("t2_drained", l1tol2_req_valid, 0);

        // Downstream backpressure fills the buffer
        l1tol2_req_retry = 1'b1;
        dc_req_valid = 1'b1; dc_req_dcid = 5'd4;
        #1 chk("t3_acc1", dc_req_retry, 0);
        cyc();
        chk("t3_head_a", l1tol2_req_dcid, 4);
        dc_req_dcid = 5'd5;
        #1 chk("t3_acc2", dc_req_retry, 0);
        cyc();
        chk("t3_head_b", l1tol2_req_dcid, 4);
        dc_req_dcid = 5'd6;
        #1 chk("t3_full_retry", dc_req_retry, 1);
        cyc();
        chk("t3_head_c", l1tol2_req_dcid, 4);
        chk("t3_valid_c", l1tol2_req_valid, 1);
        l1tol2_req_retry = 1'b0;
        #1 chk("t3_pop_no_space", dc_req_retry, 1);
        cyc();
        chk("t3_out2", l1tol2_req_dcid, 5);
        #1 chk("t3_acc3", dc_req_retry, 0);
        cyc();
        chk("t3_out3", l1tol2_req_dcid, 6);
        dc_req_valid = 1'b0;
        cyc();
        chk("t3_drained", l1tol2_req_valid, 0);

        // Prefetch starvation override: granted on its 16th valid cycle, twice
        dc_req_valid = 1'b1; dc_req_dcid = 5'd1;
        ic_req_valid = 1'b1; ic_req_dcid = 5'd2;
        pf_req_valid = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int c = 1; c <= 16; c++) begin
                #1 chk("t4_pf_retry", pf_req_retry, (c == 16) ? 1'b0 : 1'b1);
                cyc();
                if (c == 16) begin
                    chk("t4_pf_dcid", l1tol2_req_dcid, 31);
                    chk("t4_pf_cmd", l1tol2_req_cmd, 7);
                    chk("t4_pf_pcsign", l1tol2_req_pcsign, 0);
                    chk("t4_pf_laddr", l1tol2_req_laddr, 39'h2000);
                    chk("t4_pf_sptbr", l1tol2_req_sptbr, 38'h55);
                    chk("t4_pf_wait_clr", dut.r_pf_wait, 0);
                end
            end
        end
        dc_req_valid = 1'b0; ic_req_valid = 1'b0; pf_req_valid = 1'b0;
        cyc();
        chk("t4_drained", l1tol2_req_valid, 0);

        // Prefetch alone into an empty buffer
        pf_req_valid = 1'b1; pf_req_laddr = 39'h3000;
        #1 chk("t5_pf_retry", pf_req_retry, 0);
        chk("t5_pf_wait", dut.r_pf_wait, 0);
        cyc();
        chk("t5_valid", l1tol2_req_valid, 1);
        chk("t5_dcid", l1tol2_req_dcid, 31);
        chk("t5_laddr", l1tol2_req_laddr, 39'h3000);
        chk("t5_pf_wait2", dut.r_pf_wait, 0);
        pf_req_valid = 1'b0;
        cyc();
        chk("t5_drained", l1tol2_req_valid, 0);

        // Reset with a full buffer and all sources valid
        l1tol2_req_retry = 1'b1;
        dc_req_valid = 1'b1; dc_req_dcid = 5'd7;
        cyc(); cyc();
        chk("t6_full_valid", l1tol2_req_valid, 1);
        ic_req_valid = 1'b1; ic_req_dcid = 5'd8; pf_req_valid = 1'b1;
        #1 chk("t6_full_retry", dc_req_retry, 1);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("t6_rst_valid", l1tol2_req_valid, 0);
        chk("t6_rst_dc_retry", dc_req_retry, 1);
        chk("t6_rst_ic_retry", ic_req_retry, 1);
        chk("t6_rst_pf_retry", pf_req_retry, 1);
        chk("t6_rst_dcid", l1tol2_req_dcid, 0);
        chk("t6_rst_laddr", l1tol2_req_laddr, 0);
        cyc();
        chk("t6_rst_hold", l1tol2_req_valid, 0);
        reset = 1'b1; l1tol2_req_retry = 1'b0; pf_req_valid = 1'b0;
        #1 chk("t6_dc_first", dc_req_retry, 0);
        chk("t6_ic_waits", ic_req_retry, 1);
        cyc();
        chk("t6_out_valid", l1tol2_req_valid, 1);
        chk("t6_out_dcid", l1tol2_req_dcid, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/l2_req_arbiter.md
Name: l2_req_arbiter

Overview:
- Upstream neighbour of the L2 pipeline request port.
- Merges three request sources onto the single L1-to-L2 request channel: dcache requests, icache requests, and prefetch requests. Prefetch requests are promoted to full requests.
- Arbitration is round-robin between dcache and icache. Prefetch has lowest priority, with an anti-starvation override.
- A 2-entry output buffer decouples the downstream retry from the source retries.

Parameters:
- DCID_W, 5, width of L1 request id.
- CMD_W, 3, width of request command.
- PCSIGN_W, 13, width of PC signature.
- LADDR_W, 39, width of logical address.
- SPTBR_W, 38, width of page-table base.
- PF_CMD, 3'd7, command value inserted for prefetch requests.
- PF_DCID, 5'd31, request id inserted for prefetch requests.
- PF_STARVE, 15, cycles a prefetch may lose before it gets top priority (1..255).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset asserted).
- dc_req_valid  in  1  dcache request valid.
- dc_req_retry  out  1  dcache request not accepted this cycle.
- dc_req_dcid / dc_req_cmd / dc_req_pcsign / dc_req_laddr / dc_req_sptbr  in  DCID_W / CMD_W / PCSIGN_W / LADDR_W / SPTBR_W  dcache request fields.
- ic_req_valid  in  1  icache request valid.
- ic_req_retry  out  1  icache request not accepted.
- ic_req_dcid / ic_req_cmd / ic_req_pcsign / ic_req_laddr / ic_req_sptbr  in  same widths  icache request fields.
- pf_req_valid  in  1  prefetch request valid.
- pf_req_retry  out  1  prefetch request not accepted.
- pf_req_laddr  in  LADDR_W  prefetch address.
- pf_req_sptbr  in  SPTBR_W  prefetch page-table base.
- l1tol2_req_valid  out  1  merged request valid.
- l1tol2_req_retry  in  1  L2 not accepting.
- l1tol2_req_dcid / l1tol2_req_cmd / l1tol2_req_pcsign / l1tol2_req_laddr / l1tol2_req_sptbr  out  same widths  merged request fields.

Behaviour:
- Handshake: a transfer occurs on a channel when valid=1 and retry=0 in the same cycle. Sources hold their request until accepted. Retry may change regardless of valid.
- Buffer: 2-entry FIFO with count register (0..2).
  - space = (count < 2), computed from the registered count only. A same-cycle pop does not create space.
  - Push happens when any source is granted. Pop happens when l1tol2_req_valid && !l1tol2_req_retry.
  - count_next = count + push - pop.
- l1tol2_req_valid = (count != 0). Output fields are the head entry, driven directly from registers.
- Output fields are stable while valid=1 and retry=1.
- Grant (combinational, only when space=1 and reset deasserted):
  1. pf_req_valid && pf_wait == PF_STARVE → grant pf.
  2. Else if dc and ic are both valid → grant the one not equal to rr_last.
  3. Else grant whichever of dc/ic is valid.
  4. Else if pf_req_valid → grant pf.
- Source retry: X_req_retry = !(grant == X). A source with valid=0 therefore also sees retry=1 unless it is granted.
- Prefetch promotion: the pushed entry uses dcid=PF_DCID, cmd=PF_CMD, pcsign=0, laddr/sptbr taken from the pf inputs.
- rr_last: set to dc on a dc grant and to ic on an ic grant. Unchanged on a pf grant or no grant.
- pf_wait counter, width clog2(PF_STARVE+1):
  - Increments, saturating at PF_STARVE, each cycle pf_req_valid=1 and pf is not granted. This includes cycles with no space.
  - Clears to 0 when pf is granted or pf_req_valid=0.
- Reset (reset=0, asynchronous):
  - count=0, l1tol2_req_valid=0, pf_wait=0, rr_last=ic (so dc wins the first tie), FIFO read/write pointers=0.
  - All X_req_retry=1 while reset=0.
  - Output data fields reset to 0.
- Reset mid-operation: all buffered entries are discarded. No partial transfer is completed.
- Latency: a request accepted in cycle N is visible on l1tol2_req in cycle N+1 if the buffer is empty.
- Throughput: 1 request per cycle when the downstream never retries.
- Full buffer with a simultaneous pop: no push that cycle. The source sees retry=1 and is accepted the next cycle.

Test Plan:
- Reset release, dc_req_valid=1, dcid=3, laddr=0x100, l1tol2_req_retry=0 → dc_req_retry=0 in cycle 0; l1tol2_req_valid=1 with dcid=3, laddr=0x100 in cycle 1; single transfer.
- dc and ic both valid continuously (dcid 1 and 2), no downstream retry → output dcid sequence 1,2,1,2…; each source sees retry=1 on alternate cycles.
- l1tol2_req_retry held 1, dc valid for 3 requests → 2 accepted (count=2), third sees dc_req_retry=1; output holds the first entry stable. Release retry → three requests emerge in order, one per cycle; the third is accepted only the cycle after the first pop.
- dc and ic valid continuously, pf_req_valid=1 with laddr=0x2000, PF_STARVE=15 → pf granted exactly on its 16th valid cycle. Output shows dcid=31, cmd=7, pcsign=0, laddr=0x2000; pf_wait returns to 0.
- Only pf valid, empty buffer → pf accepted immediately; pf_wait stays 0.
- Assert reset=0 with count=2 and all sources valid → l1tol2_req_valid falls to 0 asynchronously; all retries are 1. After release, dc wins the first tie against ic.
